// File: rtl/two_input_xor_splitter.sv
// Splits 8-bit packets into address/data tokens through two independent 2-deep FIFOs.
// After reset the address FIFO holds one preamble token (LOCAL_ADDR) for the downstream XOR stage.
module two_input_xor_splitter #(
  parameter logic [3:0] LOCAL_ADDR = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       addr_valid,
  input  logic       addr_ready,
  output logic [3:0] addr_data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [3:0] data_data,
  output logic [7:0] pkt_count
);

  typedef enum logic {PREAMBLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_reg;
  state_t          state_next;
  logic            accept;
  logic [7:0]      pkt_count_reg;

  // Index 0 is the data FIFO, index 1 the address FIFO, matching in_data nibble order.
  logic [1:0]      fifo_ready;
  logic [1:0]      fifo_valid;
  logic [1:0]      fifo_full;
  logic [1:0][3:0] fifo_head;

  assign fifo_ready = {addr_ready, data_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      localparam logic [3:0] RESET_HEAD  = (gi == 1) ? LOCAL_ADDR : 4'h0;
      localparam logic [1:0] RESET_COUNT = (gi == 1) ? 2'd1 : 2'd0;

      logic [3:0] head_reg;
      logic [3:0] tail_reg;
      logic [1:0] count_reg;
      logic       push;
      logic       pop;
      logic [3:0] push_val;

      assign push     = accept;
      assign pop      = fifo_valid[gi] & fifo_ready[gi];
      assign push_val = in_data[gi*4 +: 4];

      always_ff @(posedge clk) begin
        if (reset) begin
          head_reg  <= RESET_HEAD;
          tail_reg  <= 4'h0;
          count_reg <= RESET_COUNT;
        end else begin
          case ({push, pop})
            2'b10: begin
              if (count_reg == 2'd0) head_reg <= push_val;
              else                   tail_reg <= push_val;
              count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
              head_reg  <= tail_reg;
              count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
              // Count stays put; with one entry the new token becomes head directly.
              if (count_reg == 2'd1) begin
                head_reg <= push_val;
              end else begin
                head_reg <= tail_reg;
                tail_reg <= push_val;
              end
            end
            default: ;
          endcase
        end
      end

      assign fifo_valid[gi] = (count_reg != 2'd0);
      assign fifo_full[gi]  = (count_reg == 2'd2);
      assign fifo_head[gi]  = head_reg;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= PREAMBLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: leave PREAMBLE once the preamble token is taken
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PREAMBLE: if (addr_valid && addr_ready) state_next = RUN;
      RUN:      state_next = RUN;
      default:  state_next = PREAMBLE;
    endcase
  end

  // Output decode: registered state and occupancy only, no path from the readies
  always_comb begin
    in_ready = (state_reg == RUN) && !fifo_full[0] && !fifo_full[1];
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset)       pkt_count_reg <= 8'd0;
    else if (accept) pkt_count_reg <= pkt_count_reg + 8'd1;
  end

  assign addr_valid = fifo_valid[1];
  assign addr_data  = fifo_head[1];
  assign data_valid = fifo_valid[0];
  assign data_data  = fifo_head[0];
  assign pkt_count  = pkt_count_reg;

endmodule

// File: tb/tb_two_input_xor_splitter.sv
// Directed bench for two_input_xor_splitter with LOCAL_ADDR = 4'hA.
module tb_two_input_xor_splitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       addr_valid;
  logic       addr_ready;
  logic [3:0] addr_data;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] data_data;
  logic [7:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_cnt;

  two_input_xor_splitter #(.LOCAL_ADDR(4'hA)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
    .data_valid(data_valid), .data_ready(data_ready), .data_data(data_data),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; addr_ready = 1'b1; data_ready = 1'b1;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL reset_addr_valid got %b want 1", addr_valid); end
    n_checks++; if (addr_data !== 4'hA) begin n_fail++; $display("FAIL reset_addr_data got %h want a", addr_data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    n_checks++; if (data_data !== 4'h0) begin n_fail++; $display("FAIL reset_data_data got %h want 0", data_data); end
    n_checks++; if (pkt_count !== 8'd0) begin n_fail++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    in_valid = 1'b0; addr_ready = 1'b0; data_ready = 1'b0;
    reset = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic test_preamble();
    tick();
    n_checks++; if (addr_data !== 4'hA || addr_valid !== 1'b1) begin n_fail++; $display("FAIL preamble_hold got v=%b d=%h want v=1 d=a", addr_valid, addr_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL preamble_in_ready got %b want 0", in_ready); end
    addr_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL preamble_run_in_ready got %b want 1", in_ready); end
    n_checks++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL preamble_popped got %b want 0", addr_valid); end
    n_checks++; if (pkt_count !== 8'd0) begin n_fail++; $display("FAIL preamble_pkt_count got %0d want 0", pkt_count); end
  endtask

  task automatic test_single();
    addr_ready = 1'b1; data_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    n_checks++; if (addr_valid !== 1'b1 || addr_data !== 4'h3) begin n_fail++; $display("FAIL single_addr got v=%b d=%h want v=1 d=3", addr_valid, addr_data); end
    n_checks++; if (data_valid !== 1'b1 || data_data !== 4'hC) begin n_fail++; $display("FAIL single_data got v=%b d=%h want v=1 d=c", data_valid, data_data); end
    n_checks++; if (pkt_count !== exp_cnt) begin n_fail++; $display("FAIL single_pkt_count got %0d want %0d", pkt_count, exp_cnt); end
    tick();
    n_checks++; if (addr_valid !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got av=%b dv=%b want 0 0", addr_valid, data_valid); end
  endtask

  task automatic test_stall();
    addr_ready = 1'b1; data_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h12;
    tick();
    in_data = 8'h34;
    tick();
    exp_cnt = exp_cnt + 8'd2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    n_checks++; if (data_valid !== 1'b1 || data_data !== 4'h2) begin n_fail++; $display("FAIL stall_data_head got v=%b d=%h want v=1 d=2", data_valid, data_data); end
    n_checks++; if (addr_valid !== 1'b1 || addr_data !== 4'h3) begin n_fail++; $display("FAIL stall_addr_head got v=%b d=%h want v=1 d=3", addr_valid, addr_data); end
    in_data = 8'h56;
    tick();
    n_checks++; if (pkt_count !== exp_cnt) begin n_fail++; $display("FAIL stall_third_blocked got %0d want %0d", pkt_count, exp_cnt); end
    n_checks++; if (data_data !== 4'h2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold got d=%h rdy=%b want d=2 rdy=0", data_data, in_ready); end
    n_checks++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_addr_independent got %b want 0", addr_valid); end
    in_valid = 1'b0; data_ready = 1'b1;
    tick();
    n_checks++; if (data_valid !== 1'b1 || data_data !== 4'h4) begin n_fail++; $display("FAIL stall_drain_second got v=%b d=%h want v=1 d=4", data_valid, data_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_back got %b want 1", in_ready); end
    tick();
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [8];
    logic [7:0] cur;
    vec = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    addr_ready = 1'b1; data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur = vec[i];
      in_valid = 1'b1; in_data = cur;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      exp_cnt++;
      $display("stream pkt %0d in=%h addr=%h data=%h count=%0d", i, cur, addr_data, data_data, pkt_count);
      n_checks++; if (addr_valid !== 1'b1 || addr_data !== cur[7:4]) begin n_fail++; $display("FAIL stream_addr[%0d] got v=%b d=%h want v=1 d=%h", i, addr_valid, addr_data, cur[7:4]); end
      n_checks++; if (data_valid !== 1'b1 || data_data !== cur[3:0]) begin n_fail++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, data_valid, data_data, cur[3:0]); end
      n_checks++; if (pkt_count !== exp_cnt) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want %0d", i, pkt_count, exp_cnt); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int misses;
    reset = 1'b1; in_valid = 1'b0; addr_ready = 1'b1; data_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    misses = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = i[7:0];
      if (in_ready !== 1'b1) misses++;
      tick();
    end
    n_checks++; if (misses != 0) begin n_fail++; $display("FAIL wrap_bubbles got %0d want 0", misses); end
    n_checks++; if (pkt_count !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d want 0", pkt_count); end
    in_data = 8'h5A;
    tick();
    n_checks++; if (pkt_count !== 8'd1) begin n_fail++; $display("FAIL wrap_257 got %0d want 1", pkt_count); end
    n_checks++; if (addr_data !== 4'h5 || data_data !== 4'hA) begin n_fail++; $display("FAIL wrap_last_tokens got %h/%h want 5/a", addr_data, data_data); end
  endtask

  task automatic test_reset_full();
    addr_ready = 1'b0; data_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    n_checks++; if (in_ready !== 1'b0 || pkt_count !== 8'd2) begin n_fail++; $display("FAIL full_setup got rdy=%b cnt=%0d want rdy=0 cnt=2", in_ready, pkt_count); end
    n_checks++; if (addr_data !== 4'h5 || data_data !== 4'hA) begin n_fail++; $display("FAIL full_heads got %h/%h want 5/a", addr_data, data_data); end
    reset = 1'b1; addr_ready = 1'b1; data_ready = 1'b1;
    tick();
    n_checks++; if (addr_valid !== 1'b1 || addr_data !== 4'hA) begin n_fail++; $display("FAIL rstfull_addr got v=%b d=%h want v=1 d=a", addr_valid, addr_data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_data_valid got %b want 0", data_valid); end
    n_checks++; if (pkt_count !== 8'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstfull_cnt_rdy got cnt=%0d rdy=%b want 0 0", pkt_count, in_ready); end
    reset = 1'b0; in_valid = 1'b0; addr_ready = 1'b0;
    tick();
    n_checks++; if (addr_data !== 4'hA || in_ready !== 1'b0) begin n_fail++; $display("FAIL reissue_preamble got d=%h rdy=%b want d=a rdy=0", addr_data, in_ready); end
    addr_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || addr_valid !== 1'b0) begin n_fail++; $display("FAIL reissue_run got rdy=%b av=%b want 1 0", in_ready, addr_valid); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; addr_ready = 1'b0; data_ready = 1'b0;
    exp_cnt = 8'd0;
    test_reset();
    test_preamble();
    test_single();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
